// File: rtl/gate_sweep_ctrl.sv
// Sweeps every minterm into a 1..4-input gate, samples its output after a
// settle interval, and grades the captured truth table against EXPECT.
module gate_sweep_ctrl #(
  parameter int                     N_IN   = 2,
  parameter int                     SETTLE = 1,
  parameter logic [(2**N_IN)-1:0]   EXPECT = 4'b0010
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic [N_IN-1:0]        dut_in,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic [(2**N_IN)-1:0]   table_out,
  output logic                   pass,
  output logic [N_IN:0]          mismatch_cnt
);

  localparam int NM = 2**N_IN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] M_LAST   = N_IN'(NM - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state, state_nx;
  logic [N_IN-1:0]   m;
  logic [CW-1:0]     cnt;
  logic              sample, last;
  logic [NM-1:0]     table_nx;

  always_comb begin
    state_nx    = state;
    sample      = (state == WAIT) && !abort && (cnt == CNT_LAST);
    last        = (m == M_LAST);
    // pass on the final edge must include the sample taken on that edge
    table_nx    = table_out;
    table_nx[m] = dut_out;
    case (state)
      IDLE:    if (start) state_nx = WAIT;
      WAIT:    if (abort) state_nx = IDLE;
               else if (sample && last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m            <= '0;
      cnt          <= '0;
      dut_in       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      table_out    <= '0;
      pass         <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          m            <= '0;
          cnt          <= '0;
          dut_in       <= '0;
          busy         <= 1'b1;
          table_out    <= '0;
          pass         <= 1'b0;
          mismatch_cnt <= '0;
        end
        WAIT: begin
          if (abort) begin
            // partial table and count are kept for post-mortem inspection
            dut_in <= '0;
            busy   <= 1'b0;
            pass   <= 1'b0;
            cnt    <= '0;
          end else if (cnt != CNT_LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            table_out <= table_nx;
            if (dut_out != EXPECT[m]) mismatch_cnt <= mismatch_cnt + 1'b1;
            if (last) begin
              busy <= 1'b0;
              done <= 1'b1;
              pass <= (table_nx == EXPECT);
            end else begin
              m      <= m + 1'b1;
              dut_in <= m + 1'b1;
              cnt    <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: default instance plus a SETTLE=3 instance.
module tb_gate_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, faulty = 1'b0;
  logic [1:0] dut_in;
  logic       dut_out, busy, done, pass;
  logic [3:0] table_out;
  logic [2:0] mismatch_cnt;

  logic start3 = 1'b0, abort3 = 1'b0;
  logic [1:0] dut_in3;
  logic       dut_out3, busy3, done3, pass3;
  logic [3:0] table_out3;
  logic [2:0] mismatch_cnt3;

  int total = 0;
  int bad   = 0;

  // faulty gate truth table, bit m = output for minterm m
  localparam logic [3:0] FAULTY_TBL = 4'b1011;

  assign dut_out  = faulty ? FAULTY_TBL[dut_in] : (~dut_in[1] & dut_in[0]);
  assign dut_out3 = ~dut_in3[1] & dut_in3[0];

  always #5 clk = ~clk;

  gate_sweep_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
    .table_out(table_out), .pass(pass), .mismatch_cnt(mismatch_cnt)
  );

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(3), .EXPECT(4'b0010)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
    .dut_in(dut_in3), .dut_out(dut_out3), .busy(busy3), .done(done3),
    .table_out(table_out3), .pass(pass3), .mismatch_cnt(mismatch_cnt3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) step();
    total++;
    if ({dut_in, busy, done, table_out, pass, mismatch_cnt} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs got=%0h exp=0", {dut_in, busy, done, table_out, pass, mismatch_cnt});
    end
    total++;
    if ({dut_in3, busy3, done3, table_out3, pass3, mismatch_cnt3} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs3 got=%0h exp=0", {dut_in3, busy3, done3, table_out3, pass3, mismatch_cnt3});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_correct();
    faulty = 1'b0;
    start = 1'b1;
    step();  // E0
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      total++;
      if (dut_in !== 2'(k) || busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL correct_seq_E%0d got in=%0d busy=%b done=%b exp in=%0d busy=1 done=0", k, dut_in, busy, done, k);
      end
    end
    step();  // E4
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL correct_done got done=%b busy=%b exp done=1 busy=0", done, busy);
    end
    total++;
    if (table_out !== 4'b0010 || pass !== 1'b1 || mismatch_cnt !== 3'd0) begin
      bad++;
      $display("FAIL correct_result got tbl=%b pass=%b mis=%0d exp tbl=0010 pass=1 mis=0", table_out, pass, mismatch_cnt);
    end
    step();  // E5
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL correct_done_width got done=%b exp 0", done);
    end
  endtask

  task automatic test_faulty();
    faulty = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    total++;
    if (done !== 1'b1 || table_out !== 4'b1011 || pass !== 1'b0 || mismatch_cnt !== 3'd2) begin
      bad++;
      $display("FAIL faulty_result got done=%b tbl=%b pass=%b mis=%0d exp done=1 tbl=1011 pass=0 mis=2", done, table_out, pass, mismatch_cnt);
    end
    repeat (4) step();
    total++;
    if (busy !== 1'b0 || table_out !== 4'b1011 || pass !== 1'b0 || mismatch_cnt !== 3'd2) begin
      bad++;
      $display("FAIL faulty_hold got busy=%b tbl=%b pass=%b mis=%0d exp busy=0 tbl=1011 pass=0 mis=2", busy, table_out, pass, mismatch_cnt);
    end
    faulty = 1'b0;
  endtask

  task automatic test_settle3();
    int exp_in;
    start3 = 1'b1;
    step();  // E0
    start3 = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      step();
      exp_in = (j < 12) ? j / 3 : 3;
      total++;
      if (dut_in3 !== 2'(exp_in) || done3 !== (j == 12) || busy3 !== (j < 12)) begin
        bad++;
        $display("FAIL settle3_E%0d got in=%0d done=%b busy=%b exp in=%0d done=%b busy=%b",
                 j, dut_in3, done3, busy3, exp_in, (j == 12), (j < 12));
      end
    end
    total++;
    if (table_out3 !== 4'b0010 || pass3 !== 1'b1 || mismatch_cnt3 !== 3'd0) begin
      bad++;
      $display("FAIL settle3_result got tbl=%b pass=%b mis=%0d exp tbl=0010 pass=1 mis=0", table_out3, pass3, mismatch_cnt3);
    end
    step();
    total++;
    if (done3 !== 1'b0) begin
      bad++;
      $display("FAIL settle3_done_width got done=%b exp 0", done3);
    end
  endtask

  task automatic test_abort();
    int seen_done = 0;
    start = 1'b1;
    step();  // E0
    start = 1'b0;
    step();  // E1
    abort = 1'b1;
    step();  // E2
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || dut_in !== 2'd0 || pass !== 1'b0 || done !== 1'b0 ||
        table_out !== 4'b0000 || mismatch_cnt !== 3'd0) begin
      bad++;
      $display("FAIL abort_state got busy=%b in=%0d pass=%b done=%b tbl=%b mis=%0d exp 0 0 0 0 0000 0",
               busy, dut_in, pass, done, table_out, mismatch_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    total++;
    if (seen_done != 0) begin
      bad++;
      $display("FAIL abort_quiet got active_cycles=%0d exp 0", seen_done);
    end
    // restart, with a stray start pulse in WAIT that must not disturb timing
    start = 1'b1;
    step();  // E0
    start = 1'b0;
    step();  // E1
    start = 1'b1;
    step();  // E2
    start = 1'b0;
    step();  // E3
    total++;
    if (done !== 1'b0 || dut_in !== 2'd3) begin
      bad++;
      $display("FAIL abort_restart_E3 got done=%b in=%0d exp done=0 in=3", done, dut_in);
    end
    step();  // E4
    total++;
    if (done !== 1'b1 || pass !== 1'b1 || table_out !== 4'b0010) begin
      bad++;
      $display("FAIL abort_restart_done got done=%b pass=%b tbl=%b exp 1 1 0010", done, pass, table_out);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic exp_busy, exp_done;
    start = 1'b1;
    for (int e = 0; e <= 11; e++) begin
      step();
      exp_busy = ((e % 6) < 4);
      exp_done = ((e % 6) == 4);
      total++;
      if (busy !== exp_busy || done !== exp_done) begin
        bad++;
        $display("FAIL b2b_E%0d got busy=%b done=%b exp busy=%b done=%b", e, busy, done, exp_busy, exp_done);
      end
    end
    start = 1'b0;
    step();
    total++;
    if (busy !== 1'b0 || pass !== 1'b1) begin
      bad++;
      $display("FAIL b2b_stop got busy=%b pass=%b exp busy=0 pass=1", busy, pass);
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    step();  // E0
    start = 1'b0;
    step();
    step();  // E2, bit 1 captured
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({dut_in, busy, done, table_out, pass, mismatch_cnt} !== 12'h000) begin
      bad++;
      $display("FAIL async_reset got=%0h exp=0", {dut_in, busy, done, table_out, pass, mismatch_cnt});
    end
    step();
    rst_n = 1'b1;
    repeat (3) step();
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || dut_in !== 2'd0) begin
      bad++;
      $display("FAIL async_reset_idle got busy=%b done=%b in=%0d exp 0 0 0", busy, done, dut_in);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    total++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      bad++;
      $display("FAIL async_reset_resweep got done=%b pass=%b exp 1 1", done, pass);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_correct();
    test_faulty();
    test_settle3();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
